uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//   Asynchronous serial transmitter. It is the stage downstream of the ASCII/hex
//   coder that feeds the wishbone debug UART.
//   Accepts one character per start strobe and shifts it out on the TX line:
//   start bit, data bits LSB first, optional parity bit, then stop bit(s).
//   Reports busy and done so the coder can pace characters.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per serial bit, >=2 (434 = 115200 baud at 50 MHz)
//   DATA_BITS     8    data bits per frame, 5..8
//   PARITY        0    0 = none, 1 = odd, 2 = even
//   STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//   i_clk      in   1          system clock, all logic on rising edge
//   i_reset    in   1          synchronous reset, active-low (0 = reset)
//   i_char     in   DATA_BITS  character to send, sampled on the accept edge
//   i_TxStart  in   1          start request, level-sampled each clock
//   o_TxBusy   out  1          frame in progress, new starts ignored
//   o_TxDone   out  1          1-cycle pulse when a frame completes
//   o_tx       out  1          serial line, idles high
// BEHAVIOUR
//   - Clocking/reset: one clock domain (i_clk). Reset is synchronous, active-low.
//   - Reset values (i_reset=0 at an edge): o_tx=1, o_TxBusy=0, o_TxDone=0,
//     FSM=IDLE, all counters 0.
//     Reset mid-frame aborts the frame at that edge; no partial completion;
//     no o_TxDone pulse.
//   - Frame length: F = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
//     Each bit is held for exactly CLKS_PER_BIT cycles.
//   - Accept: i_TxStart=1 and o_TxBusy=0 at edge E0.
//     At E0, i_char is latched into the shift register, o_tx<=0 (start bit)
//     and o_TxBusy<=1.
//     i_TxStart while o_TxBusy=1 is ignored; it is not queued.
//     i_char changes after E0 do not affect the frame.
//   - Bit timing: bit n of the frame occupies the cycles between edge
//     E0+n*CLKS_PER_BIT and edge E0+(n+1)*CLKS_PER_BIT.
//   - Done: at edge E0+F*CLKS_PER_BIT, o_TxBusy<=0 and o_TxDone<=1 for one cycle.
//     o_tx stays 1.
//   - Back-to-back: a held i_TxStart is next accepted at edge
//     E0+F*CLKS_PER_BIT+1. This gives exactly one extra idle-high cycle
//     between frames.
//     o_TxBusy is low for exactly that one cycle.
//   - FSM states:
//     IDLE -> START on accept.
//     START -> DATA after CLKS_PER_BIT cycles.
//     DATA -> PARITY (or STOP if PARITY=0) after DATA_BITS bit periods.
//     PARITY -> STOP after one bit period.
//     STOP -> IDLE after STOP_BITS bit periods.
//   - Counters:
//     Baud counter is $clog2(CLKS_PER_BIT) bits; it counts 0..CLKS_PER_BIT-1
//     and wraps at the bit boundary.
//     Bit index counter is 3 bits. Stop counter is 1 bit.
//     No counter runs in IDLE.
//   - Data path: data shifts right, LSB first. Unused upper bits of i_char
//     (DATA_BITS<8 case) are ignored.
//   - Parity is computed over the latched data bits only.
//     Odd: line bit = ~^data. Even: line bit = ^data.
//   - o_tx is driven directly from a register (glitch-free, no combinational path).
//   - i_TxStart asserted in the same cycle as i_reset=0: reset wins and nothing
//     is accepted.
// TESTING
//   1 Reset:
//     Hold i_reset=0 for 3 clocks with i_TxStart=1.
//     -> o_tx=1, o_TxBusy=0, o_TxDone=0 throughout; no frame after release
//        until i_TxStart is sampled with reset high.
//   2 Basic frame (CLKS_PER_BIT=4, 8N1):
//     Send i_char=8'h36.
//     -> o_tx = 0,0,1,1,0,1,1,0,0,1, each bit held 4 cycles.
//     -> o_TxBusy high for exactly 40 cycles; o_TxDone pulses on cycle 40.
//   3 Start while busy:
//     Pulse i_TxStart with 8'h41 at cycle 10 of a frame carrying 8'h36.
//     -> line carries only 8'h36; no second frame; o_TxDone pulses once.
//   4 Back-to-back:
//     Hold i_TxStart=1 while presenting 8'h31 then 8'h32.
//     -> two contiguous frames separated by exactly 1 idle-high cycle.
//     -> o_TxBusy low for exactly 1 cycle between them.
//   5 Parity (CLKS_PER_BIT=4, 8E1 then 8O1):
//     Send 8'h07.
//     -> parity bit is 1 for even and 0 for odd.
//     -> busy lasts 44 cycles.
//   6 Reset mid-frame:
//     Assert i_reset=0 at cycle 17 of a frame carrying 8'h00.
//     -> o_tx=1 and o_TxBusy=0 from that edge on; no o_TxDone pulse.
//     -> a following 8'h55 frame is bit-exact.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Paces one character per accepted start strobe and reports busy/done to the upstream coder.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_char,
    input  logic                 i_TxStart,
    output logic                 o_TxBusy,
    output logic                 o_TxDone,
    output logic                 o_tx
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state,   w_state;
    logic [BAUD_W-1:0]     r_baud,    w_baud;
    logic [2:0]            r_bit_idx, w_bit_idx;
    logic                  r_stop,    w_stop;
    logic [DATA_BITS-1:0]  r_shift,   w_shift;
    logic                  r_par,     w_par;
    logic                  r_tx,      w_tx;
    logic                  r_busy,    w_busy;
    logic                  r_done,    w_done;
    logic                  w_tick;

    assign w_tick   = (r_baud == BAUD_LAST);
    assign o_tx     = r_tx;
    assign o_TxBusy = r_busy;
    assign o_TxDone = r_done;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_stop    <= 1'b0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_baud    <= w_baud;
            r_bit_idx <= w_bit_idx;
            r_stop    <= w_stop;
            r_shift   <= w_shift;
            r_par     <= w_par;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Every output is computed one edge ahead so o_tx/o_TxBusy/o_TxDone come straight from flops.
    always_comb begin
        w_state   = r_state;
        w_baud    = r_baud;
        w_bit_idx = r_bit_idx;
        w_stop    = r_stop;
        w_shift   = r_shift;
        w_par     = r_par;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;

        if (r_state != S_IDLE) begin
            w_baud = w_tick ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_TxStart) begin
                    w_state   = S_START;
                    w_shift   = i_char;
                    w_par     = (PARITY == 1) ? ~^i_char : ^i_char;
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
                    w_baud    = '0;
                    w_bit_idx = '0;
                    w_stop    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state   = S_DATA;
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_idx = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        if (PARITY != 0) begin
                            w_state = S_PARITY;
                            w_tx    = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_tx    = 1'b1;
                            w_stop  = 1'b0;
                        end
                    end else begin
                        w_tx      = r_shift[0];
                        w_shift   = r_shift >> 1;
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                    w_stop  = 1'b0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if ((STOP_BITS == 2) && !r_stop) begin
                        w_stop = 1'b1;
                    end else begin
                        w_state   = S_IDLE;
                        w_busy    = 1'b0;
                        w_done    = 1'b1;
                        w_stop    = 1'b0;
                        w_bit_idx = '0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

endmodule
